// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: sequencing core for the MY_SSD peripheral.
// Runs a two-digit BCD counter at a programmable tick rate.
// Scans both digits onto the shared Pmod SSD segment bus and CAT pin.
// Segments are forced dark around every CAT change so the previous
// digit does not ghost onto the newly selected one.
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int DIV_W       = 32
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             cfg_enable,
  input  logic             cfg_up,
  input  logic             cfg_lz_blank,
  input  logic             cfg_load,
  input  logic [7:0]       cfg_load_val,
  input  logic [DIV_W-1:0] cfg_tick_div,
  output logic [7:0]       count_out,
  output logic             tick_out,
  output logic             wrap_out,
  output logic [6:0]       seg,
  output logic             cat
);

  // One shared phase timer serves both the lit and dark phases,
  // so it is sized for the longer of the two.
  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] SHOW_RELOAD  = TMR_W'(REFRESH_DIV - 1);
  localparam logic [TMR_W-1:0] BLANK_RELOAD = TMR_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    SHOW_LO  = 2'd0,
    BLANK_HI = 2'd1,
    SHOW_HI  = 2'd2,
    BLANK_LO = 2'd3
  } scan_state_t;

  // Seven-segment decode, {g,f,e,d,c,b,a} active-high.
  // Codes above 9 cannot occur in the counter; they show a dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
    return pattern;
  endfunction

  // A loaded digit above 9 would break the BCD carry logic,
  // so it is pinned to 9 on the way in.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

  // ---------------------------------------------------------------
  // Prescaler and BCD counter
  // ---------------------------------------------------------------
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] tick_limit;
  logic             step;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [3:0]       ones_next;
  logic [3:0]       tens_next;
  logic             step_wrap;

  assign ones = count_out[3:0];
  assign tens = count_out[7:4];

  // Step decision: a zero divider behaves like 1 (step every cycle), and
  // using >= lets a shrunk divider recover on the very next cycle.
  always_comb begin
    tick_limit = (cfg_tick_div == '0) ? DIV_W'(1) : cfg_tick_div;
    step       = cfg_enable && (presc >= (tick_limit - DIV_W'(1)));
  end

  // Next BCD value for one step in the selected direction, with wrap flag.
  always_comb begin
    ones_next = ones;
    tens_next = tens;
    step_wrap = 1'b0;
    if (cfg_up) begin
      if (ones >= 4'd9) begin
        ones_next = 4'd0;
        if (tens >= 4'd9) begin
          tens_next = 4'd0;
          step_wrap = 1'b1;
        end else begin
          tens_next = tens + 4'd1;
        end
      end else begin
        ones_next = ones + 4'd1;
      end
    end else begin
      if (ones == 4'd0) begin
        ones_next = 4'd9;
        if (tens == 4'd0) begin
          tens_next = 4'd9;
          step_wrap = 1'b1;
        end else begin
          tens_next = tens - 4'd1;
        end
      end else begin
        ones_next = ones - 4'd1;
      end
    end
  end

  // Counter state: a load beats a step and restarts the prescaler
  // with no pulses; a step updates the count and pulses tick/wrap.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      count_out <= 8'h00;
      presc     <= '0;
      tick_out  <= 1'b0;
      wrap_out  <= 1'b0;
    end else begin
      tick_out <= 1'b0;
      wrap_out <= 1'b0;
      if (cfg_load) begin
        count_out <= {clamp_bcd(cfg_load_val[7:4]), clamp_bcd(cfg_load_val[3:0])};
        presc     <= '0;
      end else if (cfg_enable) begin
        if (step) begin
          presc     <= '0;
          count_out <= {tens_next, ones_next};
          tick_out  <= 1'b1;
          wrap_out  <= step_wrap;
        end else begin
          presc <= presc + DIV_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Digit scan FSM
  // ---------------------------------------------------------------
  scan_state_t      state;
  scan_state_t      state_next;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic [6:0]       seg_next;
  logic             cat_next;

  // Scan state register; the FSM free-runs regardless of cfg_enable.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= SHOW_LO;
      timer <= SHOW_RELOAD;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Phase sequencing and the pin values each phase should drive.
  always_comb begin
    state_next = state;
    timer_next = timer - TMR_W'(1);
    seg_next   = 7'h00;
    cat_next   = 1'b0;

    if (timer == '0) begin
      case (state)
        SHOW_LO: begin
          state_next = BLANK_HI;
          timer_next = BLANK_RELOAD;
        end
        BLANK_HI: begin
          state_next = SHOW_HI;
          timer_next = SHOW_RELOAD;
        end
        SHOW_HI: begin
          state_next = BLANK_LO;
          timer_next = BLANK_RELOAD;
        end
        BLANK_LO: begin
          state_next = SHOW_LO;
          timer_next = SHOW_RELOAD;
        end
        default: begin
          state_next = SHOW_LO;
          timer_next = SHOW_RELOAD;
        end
      endcase
    end

    case (state)
      SHOW_LO: begin
        seg_next = decode_digit(ones);
        cat_next = 1'b0;
      end
      BLANK_HI: begin
        seg_next = 7'h00;
        cat_next = 1'b1;
      end
      SHOW_HI: begin
        seg_next = (cfg_lz_blank && (tens == 4'd0)) ? 7'h00 : decode_digit(tens);
        cat_next = 1'b1;
      end
      BLANK_LO: begin
        seg_next = 7'h00;
        cat_next = 1'b0;
      end
      default: begin
        seg_next = 7'h00;
        cat_next = 1'b0;
      end
    endcase
  end

  // Pin registers: one cycle behind state/count, so CAT only ever
  // changes in a cycle where the segments are already dark.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      seg <= 7'h00;
      cat <= 1'b0;
    end else begin
      seg <= seg_next;
      cat <= cat_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed bench for ssd_scan_ctrl with a short scan
// (8 lit cycles, 2 dark cycles) so whole scan periods fit in a few dozen clocks.
module tb_ssd_scan_ctrl;

  localparam int DIV_W = 16;

  logic             ACLK;
  logic             ARESETN;
  logic             cfg_enable;
  logic             cfg_up;
  logic             cfg_lz_blank;
  logic             cfg_load;
  logic [7:0]       cfg_load_val;
  logic [DIV_W-1:0] cfg_tick_div;
  logic [7:0]       count_out;
  logic             tick_out;
  logic             wrap_out;
  logic [6:0]       seg;
  logic             cat;

  int checks = 0;
  int errors = 0;

  ssd_scan_ctrl #(
    .REFRESH_DIV(8),
    .BLANK_CYC  (2),
    .DIV_W      (DIV_W)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cfg_enable  (cfg_enable),
    .cfg_up      (cfg_up),
    .cfg_lz_blank(cfg_lz_blank),
    .cfg_load    (cfg_load),
    .cfg_load_val(cfg_load_val),
    .cfg_tick_div(cfg_tick_div),
    .count_out   (count_out),
    .tick_out    (tick_out),
    .wrap_out    (wrap_out),
    .seg         (seg),
    .cat         (cat)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Absolute time limit so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Single comparison point: counts every check and reports a miss.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence: scan timing, reset, leading-zero blank, counting, load.
  initial begin
    logic [6:0] exp_seg;
    logic       exp_cat;
    logic       prev_cat;

    ARESETN      = 1'b0;
    cfg_enable   = 1'b0;
    cfg_up       = 1'b1;
    cfg_lz_blank = 1'b0;
    cfg_load     = 1'b0;
    cfg_load_val = 8'h00;
    cfg_tick_div = DIV_W'(1);

    // Reset values while held in reset.
    @(negedge ACLK);
    check_output("rst_seg", 32'(seg), 32'h00);
    check_output("rst_cat", 32'(cat), 32'h0);
    check_output("rst_count", 32'(count_out), 32'h00);
    check_output("rst_tick", 32'(tick_out), 32'h0);
    check_output("rst_wrap", 32'(wrap_out), 32'h0);

    // Release reset and load 42 on the first active edge.
    @(negedge ACLK);
    ARESETN      = 1'b1;
    cfg_load     = 1'b1;
    cfg_load_val = 8'h42;

    @(negedge ACLK);
    cfg_load = 1'b0;
    check_output("first_seg", 32'(seg), 32'h3F);
    check_output("first_cat", 32'(cat), 32'h0);
    check_output("load42_count", 32'(count_out), 32'h42);
    prev_cat = cat;

    // Scan timing: ones lit 8, dark 2 (cat=1), tens lit 8, dark 2 (cat=0).
    for (int k = 2; k <= 28; k++) begin
      @(negedge ACLK);
      if (k <= 8 || k >= 21) begin
        exp_seg = 7'h5B;
        exp_cat = 1'b0;
      end else if (k <= 10) begin
        exp_seg = 7'h00;
        exp_cat = 1'b1;
      end else if (k <= 18) begin
        exp_seg = 7'h66;
        exp_cat = 1'b1;
      end else begin
        exp_seg = 7'h00;
        exp_cat = 1'b0;
      end
      check_output($sformatf("scan_seg_%0d", k), 32'(seg), 32'(exp_seg));
      check_output($sformatf("scan_cat_%0d", k), 32'(cat), 32'(exp_cat));
      check_output($sformatf("cat_toggle_dark_%0d", k),
                   32'((cat != prev_cat) && (seg != 7'h00)), 32'h0);
      prev_cat = cat;
    end

    // Mid tens phase, then asynchronous reset takes effect without a clock.
    repeat (5) @(negedge ACLK);
    check_output("pre_rst_seg", 32'(seg), 32'h66);
    check_output("pre_rst_cat", 32'(cat), 32'h1);
    ARESETN = 1'b0;
    #1;
    check_output("async_rst_seg", 32'(seg), 32'h00);
    check_output("async_rst_cat", 32'(cat), 32'h0);
    check_output("async_rst_count", 32'(count_out), 32'h00);

    // Release with load 07 and leading-zero blanking on.
    @(negedge ACLK);
    ARESETN      = 1'b1;
    cfg_load     = 1'b1;
    cfg_load_val = 8'h07;
    cfg_lz_blank = 1'b1;

    @(negedge ACLK);
    cfg_load = 1'b0;
    check_output("rel_seg", 32'(seg), 32'h3F);
    check_output("rel_cat", 32'(cat), 32'h0);
    repeat (4) @(negedge ACLK);
    check_output("lz_ones_seg", 32'(seg), 32'h07);
    check_output("lz_ones_cat", 32'(cat), 32'h0);
    repeat (7) @(negedge ACLK);
    check_output("lz_tens_dark_seg", 32'(seg), 32'h00);
    check_output("lz_tens_dark_cat", 32'(cat), 32'h1);
    @(negedge ACLK);
    cfg_lz_blank = 1'b0;
    repeat (2) @(negedge ACLK);
    check_output("lz_off_tens_seg", 32'(seg), 32'h3F);
    check_output("lz_off_tens_cat", 32'(cat), 32'h1);

    // Up count, divider 3, starting from 98.
    @(negedge ACLK);
    cfg_tick_div = DIV_W'(3);
    cfg_up       = 1'b1;
    cfg_enable   = 1'b1;
    cfg_load     = 1'b1;
    cfg_load_val = 8'h98;
    @(negedge ACLK);
    cfg_load = 1'b0;
    check_output("up_load_count", 32'(count_out), 32'h98);
    check_output("up_load_tick", 32'(tick_out), 32'h0);
    repeat (2) @(negedge ACLK);
    check_output("up_wait_tick", 32'(tick_out), 32'h0);
    check_output("up_wait_count", 32'(count_out), 32'h98);
    @(negedge ACLK);
    check_output("up_99_count", 32'(count_out), 32'h99);
    check_output("up_99_tick", 32'(tick_out), 32'h1);
    check_output("up_99_wrap", 32'(wrap_out), 32'h0);
    @(negedge ACLK);
    check_output("up_tick_pulse", 32'(tick_out), 32'h0);
    repeat (2) @(negedge ACLK);
    check_output("up_00_count", 32'(count_out), 32'h00);
    check_output("up_00_tick", 32'(tick_out), 32'h1);
    check_output("up_00_wrap", 32'(wrap_out), 32'h1);
    @(negedge ACLK);
    check_output("up_wrap_pulse", 32'(wrap_out), 32'h0);
    check_output("up_tick_pulse2", 32'(tick_out), 32'h0);
    repeat (26) @(negedge ACLK);
    check_output("up_09_count", 32'(count_out), 32'h09);
    repeat (3) @(negedge ACLK);
    check_output("up_10_count", 32'(count_out), 32'h10);
    check_output("up_10_tick", 32'(tick_out), 32'h1);
    check_output("up_10_wrap", 32'(wrap_out), 32'h0);

    // Down count, divider 1, through the 00 -> 99 wrap.
    cfg_load     = 1'b1;
    cfg_load_val = 8'h01;
    cfg_up       = 1'b0;
    cfg_tick_div = DIV_W'(1);
    @(negedge ACLK);
    cfg_load = 1'b0;
    check_output("dn_01_count", 32'(count_out), 32'h01);
    check_output("dn_01_tick", 32'(tick_out), 32'h0);
    @(negedge ACLK);
    check_output("dn_00_count", 32'(count_out), 32'h00);
    check_output("dn_00_wrap", 32'(wrap_out), 32'h0);
    @(negedge ACLK);
    check_output("dn_99_count", 32'(count_out), 32'h99);
    check_output("dn_99_wrap", 32'(wrap_out), 32'h1);
    check_output("dn_99_tick", 32'(tick_out), 32'h1);
    @(negedge ACLK);
    check_output("dn_98_count", 32'(count_out), 32'h98);
    check_output("dn_98_wrap", 32'(wrap_out), 32'h0);
    check_output("dn_98_tick", 32'(tick_out), 32'h1);

    // Load AF on the same edge as a step: clamps to 99, no pulses.
    cfg_up       = 1'b1;
    cfg_tick_div = DIV_W'(4);
    repeat (3) @(negedge ACLK);
    cfg_load     = 1'b1;
    cfg_load_val = 8'hAF;
    @(negedge ACLK);
    cfg_load = 1'b0;
    check_output("clamp_count", 32'(count_out), 32'h99);
    check_output("clamp_tick", 32'(tick_out), 32'h0);
    check_output("clamp_wrap", 32'(wrap_out), 32'h0);
    repeat (3) @(negedge ACLK);
    check_output("clamp_hold_count", 32'(count_out), 32'h99);
    @(negedge ACLK);
    check_output("clamp_next_count", 32'(count_out), 32'h00);
    check_output("clamp_next_wrap", 32'(wrap_out), 32'h1);

    // Load mid-period restarts the prescaler from 0.
    @(negedge ACLK);
    cfg_load     = 1'b1;
    cfg_load_val = 8'h55;
    @(negedge ACLK);
    cfg_load = 1'b0;
    repeat (3) @(negedge ACLK);
    check_output("restart_hold_count", 32'(count_out), 32'h55);
    check_output("restart_hold_tick", 32'(tick_out), 32'h0);
    @(negedge ACLK);
    check_output("restart_step_count", 32'(count_out), 32'h56);
    check_output("restart_step_tick", 32'(tick_out), 32'h1);

    // Disabled: count and prescaler frozen.
    cfg_enable = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge ACLK);
      check_output($sformatf("frozen_count_%0d", i), 32'(count_out), 32'h56);
      check_output($sformatf("frozen_tick_%0d", i), 32'(tick_out), 32'h0);
    end
    cfg_enable = 1'b1;
    repeat (3) @(negedge ACLK);
    check_output("resume_hold_count", 32'(count_out), 32'h56);
    @(negedge ACLK);
    check_output("resume_step_count", 32'(count_out), 32'h57);
    check_output("resume_step_tick", 32'(tick_out), 32'h1);

    // Divider 0 behaves as 1.
    cfg_tick_div = '0;
    @(negedge ACLK);
    check_output("div0_count_a", 32'(count_out), 32'h58);
    check_output("div0_tick_a", 32'(tick_out), 32'h1);
    @(negedge ACLK);
    check_output("div0_count_b", 32'(count_out), 32'h59);
    cfg_enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
